nibble_stream_bridge: RTL and testbench

Parametrised serial front end for the dial-solver cores. It replaces fixed-count nibble shifting and a divided core clock with valid/ready handshakes on every interface. Input beats are deserialised into a full command word plus direction bit and presented to the core with a handshake. A result word from the core is serialised back out MSB-first with frame markers. The block sits between the board I/O pins and any `aoc_day1_*` core, and runs entirely on the system clock.

---
 rtl/nibble_stream_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_nibble_stream_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_stream_bridge.sv
// nibble_stream_bridge
//   Serial front end for the dial-solver cores. Input beats (MSB beat first)
//   are deserialised into a WORD_W command word plus a direction bit and
//   offered to the core over a valid/ready handshake. A result word taken from
//   the core is serialised back out MSB beat first, with first/last markers.
//   Both paths run on sys_clk and are fully independent.
//
//   Optional feature macro: NIBBLE_BRIDGE_PARITY_EN
//     defined   -> each output frame gets one trailing beat whose bit 0 is the
//                  XOR of all result bits (other bits 0); out_last moves there.
//     undefined -> frame is exactly WORD_W/OUT_W beats, no parity logic.
//
//   Parameters: IN_W, OUT_W beat widths; WORD_W word width (integer multiple
//   of both, and at least two beats on each side).
//
//   Ports:
//     sys_clk, rst (async, active low)
//     in_valid/in_data/in_dir/in_abort -> in_ready       input beat stream
//     cmd_valid/cmd_data/cmd_dir       <- cmd_ready      command to core
//     res_valid/res_data               -> res_ready      result from core
//     out_valid/out_data/out_first/out_last <- out_ready output beat stream
module nibble_stream_bridge #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 4,
    parameter int WORD_W = 32
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_dir,
    input  logic              in_abort,
    output logic              in_ready,
    output logic              cmd_valid,
    output logic [WORD_W-1:0] cmd_data,
    output logic              cmd_dir,
    input  logic              cmd_ready,
    input  logic              res_valid,
    input  logic [WORD_W-1:0] res_data,
    output logic              res_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_first,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int IN_BEATS  = WORD_W / IN_W;
    localparam int OUT_BEATS = WORD_W / OUT_W;
`ifdef NIBBLE_BRIDGE_PARITY_EN
    localparam int FRAME_BEATS = OUT_BEATS + 1;
`else
    localparam int FRAME_BEATS = OUT_BEATS;
`endif
    localparam int IN_CNT_W  = $clog2(IN_BEATS + 1);
    localparam int OUT_CNT_W = $clog2(FRAME_BEATS + 1);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_HOLD    = 1'b1;
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_SEND    = 1'b1;

    // ---------------------------------------------------------------- input
    // sh_q only keeps the beats before the final one; the final beat is
    // appended on the fly when the command word is loaded.
    logic [0:0]             in_st_q, in_st_d;
    logic [IN_CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [WORD_W-IN_W-1:0] sh_q, sh_d;
    logic                   dir_q, dir_d;
    logic                   in_ready_q, in_ready_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [WORD_W-1:0]      cmd_data_q, cmd_data_d;
    logic                   cmd_dir_q, cmd_dir_d;
    logic [WORD_W-1:0]      sh_full;

    assign sh_full = {sh_q, in_data};

    always_comb begin
        in_st_d     = in_st_q;
        in_cnt_d    = in_cnt_q;
        sh_d        = sh_q;
        dir_d       = dir_q;
        in_ready_d  = in_ready_q;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        cmd_dir_d   = cmd_dir_q;
        case (in_st_q)
            S_COLLECT: begin
                in_ready_d = 1'b1;
                if (in_abort) begin
                    // abort wins over a same-cycle beat
                    in_cnt_d = '0;
                    sh_d     = '0;
                end else if (in_valid && in_ready_q) begin
                    sh_d = sh_full[WORD_W-IN_W-1:0];
                    if (in_cnt_q == '0) dir_d = in_dir;
                    if (in_cnt_q == IN_CNT_W'(IN_BEATS - 1)) begin
                        cmd_data_d  = sh_full;
                        cmd_dir_d   = dir_q;
                        cmd_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        in_cnt_d    = '0;
                        in_st_d     = S_HOLD;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_CNT_W'(1);
                    end
                end
            end
            default: begin
                // HOLD: cmd_valid is high here; abort is deliberately ignored
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    in_st_d     = S_COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            in_st_q     <= S_COLLECT;
            in_cnt_q    <= '0;
            sh_q        <= '0;
            dir_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            cmd_dir_q   <= 1'b0;
        end else begin
            in_st_q     <= in_st_d;
            in_cnt_q    <= in_cnt_d;
            sh_q        <= sh_d;
            dir_q       <= dir_d;
            in_ready_q  <= in_ready_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            cmd_dir_q   <= cmd_dir_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_dir   = cmd_dir_q;

    // --------------------------------------------------------------- output
    // out_data_q holds the beat on the wire; snap_q holds the beats still to
    // come, left-aligned.
    logic [0:0]              out_st_q, out_st_d;
    logic [OUT_CNT_W-1:0]    out_cnt_q, out_cnt_d, out_nxt;
    logic [WORD_W-OUT_W-1:0] snap_q, snap_d;
    logic                    res_ready_q, res_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_first_q, out_first_d;
    logic                    out_last_q, out_last_d;
`ifdef NIBBLE_BRIDGE_PARITY_EN
    logic                    par_q, par_d;
`endif

    assign out_nxt = out_cnt_q + OUT_CNT_W'(1);

    always_comb begin
        out_st_d    = out_st_q;
        out_cnt_d   = out_cnt_q;
        snap_d      = snap_q;
        res_ready_d = res_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
`ifdef NIBBLE_BRIDGE_PARITY_EN
        par_d       = par_q;
`endif
        case (out_st_q)
            S_IDLE: begin
                res_ready_d = 1'b1;
                if (res_valid && res_ready_q) begin
                    out_st_d    = S_SEND;
                    res_ready_d = 1'b0;
                    out_valid_d = 1'b1;
                    out_first_d = 1'b1;
                    out_last_d  = (FRAME_BEATS == 1);
                    out_data_d  = res_data[WORD_W-1 -: OUT_W];
                    snap_d      = res_data[WORD_W-OUT_W-1:0];
                    out_cnt_d   = '0;
`ifdef NIBBLE_BRIDGE_PARITY_EN
                    par_d       = ^res_data;
`endif
                end
            end
            default: begin
                // SEND: out_valid is high here
                if (out_ready) begin
                    if (out_last_q) begin
                        out_st_d    = S_IDLE;
                        out_valid_d = 1'b0;
                        out_first_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        out_cnt_d   = '0;
                        res_ready_d = 1'b1;
                    end else begin
                        out_cnt_d   = out_nxt;
                        out_first_d = 1'b0;
                        out_last_d  = (out_nxt == OUT_CNT_W'(FRAME_BEATS - 1));
                        out_data_d  = snap_q[WORD_W-OUT_W-1 -: OUT_W];
                        snap_d      = snap_q << OUT_W;
`ifdef NIBBLE_BRIDGE_PARITY_EN
                        if (out_nxt == OUT_CNT_W'(OUT_BEATS)) out_data_d = OUT_W'(par_q);
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            out_st_q    <= S_IDLE;
            out_cnt_q   <= '0;
            snap_q      <= '0;
            res_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef NIBBLE_BRIDGE_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            out_st_q    <= out_st_d;
            out_cnt_q   <= out_cnt_d;
            snap_q      <= snap_d;
            res_ready_q <= res_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
`ifdef NIBBLE_BRIDGE_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign res_ready = res_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_nibble_stream_bridge.sv
// Directed bench for nibble_stream_bridge (default parameters).
module tb_nibble_stream_bridge;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_dir = 1'b0;
    logic        in_abort = 1'b0;
    logic        in_ready;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_dir;
    logic        cmd_ready = 1'b1;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic        res_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_first;
    logic        out_last;
    logic        out_ready = 1'b1;

    nibble_stream_bridge dut (
        .sys_clk(sys_clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_dir(in_dir),
        .in_abort(in_abort), .in_ready(in_ready),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .out_valid(out_valid), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef NIBBLE_BRIDGE_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [0:7][3:0] beats;
        logic            dir;
        logic [31:0]     exp_data;
    } in_vec_t;

    typedef struct {
        logic [31:0] data;
        logic        par;
    } res_vec_t;

    in_vec_t  iv[4];
    res_vec_t rv[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_data"},  cmd_data,  0);
        chk({tag, "_cmd_dir"},   cmd_dir,   0);
        chk({tag, "_res_ready"}, res_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_first"}, out_first, 0);
        chk({tag, "_out_last"},  out_last,  0);
    endtask

    // one beat; in_dir is inverted on non-first beats so only beat 0 matters
    task automatic send_beat(input logic [3:0] b, input logic d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_dir   = d;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [0:7][3:0] b, input logic d, input logic [31:0] exp);
        for (int i = 0; i < 8; i++) send_beat(b[i], (i == 0) ? d : ~d);
        chk("cmd_valid_rise", cmd_valid, 1);
        chk("cmd_data",       cmd_data,  exp);
        chk("cmd_dir",        cmd_dir,   d);
        chk("in_ready_hold",  in_ready,  0);
    endtask

    // hold cmd_ready low for 'hold' cycles, then complete the handshake
    task automatic finish_cmd(input int hold, input logic [31:0] exp);
        cmd_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("cmd_valid_held", cmd_valid, 1);
            chk("cmd_data_held",  cmd_data,  exp);
            chk("in_ready_low",   in_ready,  0);
        end
        cmd_ready = 1'b1;
        tick();
        chk("cmd_valid_drop", cmd_valid, 0);
        chk("in_ready_back",  in_ready,  1);
    endtask

    task automatic recv_frame(input logic [31:0] data, input logic par, input int stall_at);
        int n = 0;
        logic [3:0] e;
        out_ready = 1'b1;
        res_valid = 1'b1;
        res_data  = data;
        while (!res_ready && n < 40) begin
            tick();
            n++;
        end
        if (!res_ready) chk("res_ready_timeout", res_ready, 1);
        tick();
        res_valid = 1'b0;
        res_data  = 32'h5A5A_0F0F;
        for (int i = 0; i < FB; i++) begin
            e = (i < 8) ? data[31-4*i -: 4] : {3'b000, par};
            chk("out_valid", out_valid, 1);
            chk("out_data",  out_data,  e);
            chk("out_first", out_first, (i == 0));
            chk("out_last",  out_last,  (i == FB - 1));
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data",  out_data,  e);
                    chk("stall_first", out_first, (i == 0));
                    chk("stall_last",  out_last,  (i == FB - 1));
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("out_valid_end", out_valid, 0);
        chk("res_ready_end", res_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iv[0].beats = {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h2};
        iv[0].dir = 1'b1; iv[0].exp_data = 32'h0000_0032;
        iv[1].beats = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        iv[1].dir = 1'b0; iv[1].exp_data = 32'h1234_5678;
        iv[2].beats = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
        iv[2].dir = 1'b1; iv[2].exp_data = 32'hFEDC_BA98;
        iv[3].beats = {4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};
        iv[3].dir = 1'b0; iv[3].exp_data = 32'hA5A5_A5A5;

        rv[0].data = 32'h1234_ABCD; rv[0].par = 1'b1;
        rv[1].data = 32'h0000_0000; rv[1].par = 1'b0;
        rv[2].data = 32'hFFFF_FFFF; rv[2].par = 1'b0;
        rv[3].data = 32'h8000_0001; rv[3].par = 1'b0;
        rv[4].data = 32'h0000_0007; rv[4].par = 1'b1;

        // reset state
        #2;
        chk_reset_outputs("rst");
        #11;
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready",  in_ready,  1);
        chk("post_rst_res_ready", res_ready, 1);
        chk("post_rst_cmd_valid", cmd_valid, 0);
        chk("post_rst_out_valid", out_valid, 0);

        // input frames
        for (int v = 0; v < 4; v++) begin
            send_frame(iv[v].beats, iv[v].dir, iv[v].exp_data);
            finish_cmd(0, iv[v].exp_data);
        end

        // result frames
        for (int v = 0; v < 5; v++) recv_frame(rv[v].data, rv[v].par, -1);

        // output backpressure on the third beat
        recv_frame(32'h1234_ABCD, 1'b1, 2);

        // command backpressure
        send_frame(iv[1].beats, iv[1].dir, iv[1].exp_data);
        finish_cmd(10, iv[1].exp_data);

        // abort in COLLECT: partial frame and the same-cycle beat are dropped
        send_beat(4'h1, 1'b0);
        send_beat(4'h2, 1'b1);
        send_beat(4'h3, 1'b1);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h5;
        tick();
        in_abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_cmd_valid", cmd_valid, 0);
        send_frame({8{4'hF}}, 1'b1, 32'hFFFF_FFFF);
        finish_cmd(0, 32'hFFFF_FFFF);

        // abort in HOLD is ignored
        send_frame(iv[2].beats, iv[2].dir, iv[2].exp_data);
        in_abort = 1'b1;
        finish_cmd(4, iv[2].exp_data);
        in_abort = 1'b0;

        // concurrent command and output stream
        fork
            begin
                send_frame(iv[3].beats, iv[3].dir, iv[3].exp_data);
                finish_cmd(0, iv[3].exp_data);
            end
            recv_frame(32'h8000_0001, 1'b0, -1);
        join

        // reset mid input frame and mid output frame
        out_ready = 1'b1;
        res_data  = 32'h1234_ABCD;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 1);
            in_dir   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge sys_clk);
        rst = 1'b1;
        tick();
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_res_ready", res_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        send_frame({4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2}, 1'b0, 32'h9876_5432);
        finish_cmd(0, 32'h9876_5432);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
